// File: rtl/UART_MIKE_pkg.sv
// rtl/UART_MIKE_pkg.sv - shared state type and defaults for the UART transmit path
package UART_MIKE_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 5208;
    localparam int UART_DATA_BITS_DEFAULT    = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a one-cycle tick at terminal count
module uart_baud_tick
    import UART_MIKE_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 (optional even parity) UART transmit serializer
module uart_tx_serializer
    import UART_MIKE_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS_DEFAULT,
    parameter int PARITY_EN    = 0,
    parameter int BIT_CNT_W    = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_tx_state_t       state, state_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic [IDX_W-1:0]     idx_q, idx_next;
    logic                 parity_q, parity_next;
    logic                 tx_q, tx_next;
    logic                 done_q, done_next;
    logic                 clr;
    logic                 tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (BIT_CNT_W)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            idx_q    <= idx_next;
            parity_q <= parity_next;
            tx_q     <= tx_next;
            done_q   <= done_next;
        end
    end

    // tx_next is the level of the line in the cycle after this edge, so tx stays a pure flop
    always_comb begin
        state_next  = state;
        shift_next  = shift_q;
        idx_next    = idx_q;
        parity_next = parity_q;
        tx_next     = tx_q;
        done_next   = 1'b0;
        clr         = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    shift_next  = tx_data;
                    parity_next = ^tx_data;
                    idx_next    = '0;
                    clr         = 1'b1;
                    tx_next     = 1'b0;
                    state_next  = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_next    = shift_q[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_q >> 1;
                    idx_next   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        tx_next    = (PARITY_EN != 0) ? parity_q : 1'b1;
                    end else begin
                        tx_next = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_next    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_next    = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer, with and without parity
module tb_uart_tx_serializer;

    localparam int C       = 4;
    localparam int DB      = 8;
    localparam int LIMIT_T = 200000;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [1:0] done_w;

    frame_t exp_q[2][$];
    int     free_edge[2];
    int     edge_n   = 0;
    bit     seen_rst = 1'b0;
    int     checks   = 0;
    int     errors   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_serializer #(
            .CLKS_PER_BIT (C),
            .DATA_BITS    (DB),
            .PARITY_EN    (g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_start (tx_start),
            .tx_data  (tx_data),
            .tx       (tx_w[g]),
            .tx_busy  (busy_w[g]),
            .tx_done  (done_w[g])
        );
    end

    function automatic logic frame_bit(input logic [7:0] data, input int b, input int pe);
        logic [7:0] v;
        v = data;
        if (b == 0) return 1'b0;
        if (b <= DB) return v[b-1];
        if (pe != 0 && b == DB + 1) return ^v;
        return 1'b1;
    endfunction

    initial begin
        free_edge[0] = 0;
        free_edge[1] = 0;
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            if (rst) seen_rst = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    exp_q[d].delete();
                    free_edge[d] = 0;
                end else if (seen_rst && tx_start && edge_n >= free_edge[d]) begin
                    exp_q[d].push_back('{data: tx_data, start: edge_n});
                    free_edge[d] = edge_n + (2 + DB + d) * C + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                for (int d = 0; d < 2; d++) begin
                    logic   et, eb, ed, pop;
                    int     k, f;
                    frame_t fr;
                    et  = 1'b1;
                    eb  = 1'b0;
                    ed  = 1'b0;
                    pop = 1'b0;
                    f   = (2 + DB + d) * C;
                    if (exp_q[d].size() > 0) begin
                        fr = exp_q[d][0];
                        k  = edge_n - fr.start;
                        if (k >= 0 && k < f) begin
                            eb = 1'b1;
                            et = frame_bit(fr.data, k / C, d);
                        end else if (k == f) begin
                            ed  = 1'b1;
                            pop = 1'b1;
                        end
                    end
                    checks = checks + 1;
                    if ({tx_w[d], busy_w[d], done_w[d]} !== {et, eb, ed}) begin
                        errors = errors + 1;
                        $display("FAIL line_p%0d cycle %0d: tx/busy/done got %b%b%b expected %b%b%b",
                                 d, edge_n, tx_w[d], busy_w[d], done_w[d], et, eb, ed);
                    end
                    if (pop) void'(exp_q[d].pop_front());
                end
            end
        end
    end

    initial begin
        #(LIMIT_T);
        errors = errors + 1;
        $display("FAIL timeout: stimulus did not complete within %0d time units", LIMIT_T);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic drive(input logic r, input logic s, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        tx_start = s;
        tx_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (tx_w !== 2'b11 || busy_w !== 2'b00 || done_w !== 2'b00) begin
            errors = errors + 1;
            $display("FAIL reset_state: tx=%b busy=%b done=%b expected tx=11 busy=00 done=00",
                     tx_w, busy_w, done_w);
        end
        idle(20);

        drive(1'b0, 1'b1, 8'hA5);
        idle(50);
        drive(1'b0, 1'b1, 8'h07);
        idle(50);

        drive(1'b0, 1'b1, 8'h55);
        idle(9);
        drive(1'b0, 1'b1, 8'hFF);
        idle(10);
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, 8'h0F);
        for (int i = 0; i < 150; i++) drive(1'b0, 1'b1, 8'($urandom));
        idle(50);

        drive(1'b0, 1'b1, 8'h00);
        idle(16);
        drive(1'b1, 1'b1, 8'hFF);
        idle(6);
        drive(1'b0, 1'b1, 8'($urandom));
        idle(50);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
